// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Parametrised up/down counter with a programmable modulus. It has a count
//   enable, a synchronous load, and either wrap or saturate behaviour at the
//   boundaries. It raises registered overflow/underflow pulses and a
//   combinational terminal-count flag.
//
// Parameters
//   WIDTH      counter width in bits (>= 1)
//   MAX_COUNT  highest legal count; the count range is 0..MAX_COUNT
//   SATURATE   0 = wrap modulo MAX_COUNT+1, 1 = hold at the boundary
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   en        count enable, one step per cycle while high
//   up_dn     direction, 1 = increment, 0 = decrement
//   load      synchronous load strobe (wins over en)
//   load_val  value captured on load, clamped to MAX_COUNT
//   counter   registered count
//   ovf       one-cycle pulse: an up-step was attempted at MAX_COUNT
//   udf       one-cycle pulse: a down-step was attempted at 0
//   tc        terminal count for the current direction (combinational)
module updown_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             ovf,
  output logic             udf,
  output logic             tc
);

  if (WIDTH < 1 || MAX_COUNT < 1 ||
      longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1)) begin : g_param_check
    $error("updown_mod_counter: MAX_COUNT=%0d is illegal for WIDTH=%0d",
           MAX_COUNT, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX = MAX_COUNT[WIDTH-1:0];

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    at_max       = (counter == MAX);
    at_zero      = (counter == '0);
    load_clamped = (load_val > MAX) ? MAX : load_val;
    tc           = up_dn ? at_max : at_zero;
  end

  // The boundary is detected before the step is taken, so the +1/-1 never
  // has to carry into a bit above WIDTH. When MAX is all ones, this gives
  // the same result as natural binary wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      ovf <= 1'b0;
      udf <= 1'b0;
      if (load) begin
        counter <= load_clamped;
      end else if (en) begin
        if (up_dn) begin
          if (at_max) begin
            counter <= SATURATE ? MAX : '0;
            ovf     <= 1'b1;
          end else begin
            counter <= counter + WIDTH'(1);
          end
        end else begin
          if (at_zero) begin
            counter <= SATURATE ? '0 : MAX;
            udf     <= 1'b1;
          end else begin
            counter <= counter - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Three counters run in lockstep on the same stimulus:
//   0: WIDTH=4, MAX_COUNT=9, wrap
//   1: WIDTH=4, MAX_COUNT=9, saturate
//   2: WIDTH=3, MAX_COUNT=7 (default), wrap
// The driver applies the inputs on the falling edge. It then advances a
// reference model for each counter and queues the expected outputs. A monitor
// pops one entry after each rising edge and compares it with all three counters.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       udf_a, udf_b, udf_c;
  logic       tc_a, tc_b, tc_c;

  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .counter(cnt_a), .ovf(ovf_a), .udf(udf_a), .tc(tc_a));

  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .counter(cnt_b), .ovf(ovf_b), .udf(udf_b), .tc(tc_b));

  updown_mod_counter #(.WIDTH(3)) dut_w3 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[2:0]), .counter(cnt_c), .ovf(ovf_c), .udf(udf_c), .tc(tc_c));

  typedef struct packed {
    logic [2:0][3:0] cnt;
    logic [2:0]      ovf;
    logic [2:0]      udf;
    logic [2:0]      tc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int m_cnt[3] = '{0, 0, 0};
  int maxv[3]  = '{9, 9, 7};
  bit satv[3]  = '{1'b0, 1'b1, 1'b0};

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d] t=%0t actual=%0d expected=%0d", name, idx, $time, act, exp);
    end
  endtask

  // Reference model: apply the priority reset > load > enable, take the
  // signed step, and then handle any step that leaves 0..max.
  task automatic drive(input bit r, input bit l, input int lv, input bit e, input bit ud);
    exp_t x;
    x = '0;
    @(negedge clk);
    reset    = r;
    load     = l;
    load_val = 4'(lv);
    en       = e;
    up_dn    = ud;
    for (int i = 0; i < 3; i++) begin
      int v;
      int t;
      bit o;
      bit u;
      o = 1'b0;
      u = 1'b0;
      v = (i == 2) ? (lv & 7) : (lv & 15);
      if (r) begin
        m_cnt[i] = 0;
      end else if (l) begin
        m_cnt[i] = (v > maxv[i]) ? maxv[i] : v;
      end else if (e) begin
        t = m_cnt[i] + (ud ? 1 : -1);
        if (t > maxv[i]) begin
          o = 1'b1;
          m_cnt[i] = satv[i] ? maxv[i] : 0;
        end else if (t < 0) begin
          u = 1'b1;
          m_cnt[i] = satv[i] ? 0 : maxv[i];
        end else begin
          m_cnt[i] = t;
        end
      end
      x.cnt[i] = 4'(m_cnt[i]);
      x.ovf[i] = o;
      x.udf[i] = u;
      x.tc[i]  = ud ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0);
    end
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    logic [2:0][3:0] act_cnt;
    logic [2:0]      act_ovf, act_udf, act_tc;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        act_cnt = {1'b0, cnt_c, cnt_b, cnt_a};
        act_ovf = {ovf_c, ovf_b, ovf_a};
        act_udf = {udf_c, udf_b, udf_a};
        act_tc  = {tc_c, tc_b, tc_a};
        for (int i = 0; i < 3; i++) begin
          check("counter", i, int'(act_cnt[i]), int'(x.cnt[i]));
          check("ovf",     i, int'(act_ovf[i]), int'(x.ovf[i]));
          check("udf",     i, int'(act_udf[i]), int'(x.udf[i]));
          check("tc",      i, int'(act_tc[i]),  int'(x.tc[i]));
        end
      end
    end
  end

  initial begin : stimulus
    // reset held, then up-count across the wrap
    repeat (2) drive(1, 0, 0, 0, 1);
    repeat (12) drive(0, 0, 0, 1, 1);
    // load wins over en, then down-count through zero
    drive(0, 1, 3, 1, 1);
    repeat (5) drive(0, 0, 0, 1, 0);
    // boundary hold/wrap at both ends
    drive(0, 1, 8, 0, 1);
    repeat (3) drive(0, 0, 0, 1, 1);
    drive(0, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0);
    // clamp on load, then idle with both directions
    drive(0, 1, 14, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // reset beats load and en mid-count
    drive(0, 1, 4, 0, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 1, 7, 1, 1);
    drive(1, 1, 7, 1, 1);
    repeat (2) drive(0, 0, 0, 1, 1);
    // direction flips on consecutive enabled edges
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(31) == 0, $urandom_range(7) == 0,
            int'($urandom_range(15)), $urandom_range(3) != 0, $urandom_range(1) == 1);
    end
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
